// File: rtl/rotate_wr_cell.sv
// rotate_wr_cell: packs a 32-bit RAM-word pixel stream into 256-bit DDR words,
// buffers them in a circular FIFO and writes each line out as DDR bursts.
module rotate_wr_cell #(
  parameter int          ADDR_WIDTH      = 27,
  parameter logic [31:0] ADDR_OFFSET     = 32'h0000_0000,
  parameter int          H_NUM           = 1920,
  parameter int          V_NUM           = 1080,
  parameter int          DQ_WIDTH        = 32,
  parameter int          LEN_WIDTH       = 16,
  parameter int          PIX_WIDTH       = 24,
  parameter int          RAM_WIDTH       = 32,
  parameter int          LINE_ADDR_WIDTH = 19,
  parameter int          FRAME_CNT_WIDTH = 8,
  parameter int          BURST_LEN       = 64,
  parameter int          FIFO_DEPTH      = 256
) (
  input  logic                   ddr_clk,
  input  logic                   ddr_rstn,
  input  logic                   wr_fsync,
  input  logic                   wr_en,
  input  logic [RAM_WIDTH-1:0]   wr_data,
  input  logic [1:0]             ddr_part,
  output logic                   ddr_wreq,
  output logic [ADDR_WIDTH-1:0]  ddr_waddr,
  output logic [LEN_WIDTH-1:0]   ddr_wr_len,
  input  logic                   ddr_wrdy,
  input  logic                   ddr_wdata_req,
  output logic [8*DQ_WIDTH-1:0]  ddr_wdata,
  input  logic                   ddr_wdone,
  output logic                   frame_done,
  output logic                   ovf
);

  localparam int DW          = 8 * DQ_WIDTH;
  localparam int LANES       = DW / RAM_WIDTH;
  localparam int WORDS_LINE  = H_NUM * PIX_WIDTH / RAM_WIDTH;
  localparam int DDR_LINE    = WORDS_LINE / LANES;
  localparam int LINE_STRIDE = DDR_LINE * 8;
  localparam int WCNT_W      = $clog2(WORDS_LINE);
  localparam int PCNT_W      = $clog2(LANES);
  localparam int LINE_W      = $clog2(V_NUM + 1);
  localparam int OFF_W       = $clog2(DDR_LINE + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WDONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_fsync_1d, r_fs_pend, r_active, r_frame_done, r_ovf;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
  logic [1:0]                 r_part_l;
  logic [LINE_W-1:0]          r_line, r_pack_line;
  logic [OFF_W-1:0]           r_burst_off;
  logic [ADDR_WIDTH-1:0]      r_waddr;
  logic [LEN_WIDTH-1:0]       r_wr_len, r_req_cnt;
  logic                       r_wdone_seen;
  logic [WCNT_W-1:0]          r_word_cnt;
  logic [PCNT_W-1:0]          r_pack_cnt;
  logic [DW-1:0]              r_pack_data, r_wdata;
  logic                       r_push_v;
  logic [PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic [DW-1:0]              r_mem [FIFO_DEPTH];

  logic                       w_fs_rise, w_apply, w_accept, w_full, w_push_ok, w_pop;
  logic                       w_launch, w_burst_end;
  logic [31:0]                w_remain, w_blen, w_off_sum;
  logic [LINE_ADDR_WIDTH-1:0] w_inner;
  logic [ADDR_WIDTH-1:0]      w_addr;

  assign w_fs_rise = wr_fsync & ~r_fsync_1d;
  assign w_apply   = (r_state == S_IDLE) && r_fs_pend;
  assign w_accept  = wr_en && r_active && !r_fs_pend && (r_pack_line < LINE_W'(V_NUM));
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_ok = r_push_v && !w_full && !w_apply;

  assign w_remain  = 32'(DDR_LINE) - 32'(r_burst_off);
  assign w_blen    = (w_remain > 32'(BURST_LEN)) ? 32'(BURST_LEN) : w_remain;
  assign w_off_sum = 32'(r_burst_off) + 32'(r_wr_len);
  // The in-part line field wraps at LINE_ADDR_WIDTH bits; parity/part sit at the top.
  assign w_inner   = LINE_ADDR_WIDTH'(32'(r_line) * 32'(LINE_STRIDE) + 32'(r_burst_off) * 32'd8);
  assign w_addr    = {r_frame_cnt[0], r_part_l, {(ADDR_WIDTH-3-LINE_ADDR_WIDTH){1'b0}}, w_inner}
                     + ADDR_OFFSET[ADDR_WIDTH-1:0];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (!r_fs_pend && r_active && (r_line < LINE_W'(V_NUM)) && (32'(r_count) >= w_blen))
                 w_state_nxt = S_REQ;
      S_REQ:   if (ddr_wrdy) w_state_nxt = S_DATA;
      S_DATA:  if (ddr_wdata_req && (r_req_cnt == r_wr_len - LEN_WIDTH'(1))) w_state_nxt = S_WDONE;
      S_WDONE: if (ddr_wdone || r_wdone_seen) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ddr_wreq    = (r_state == S_REQ);
    w_launch    = (r_state == S_IDLE) && (w_state_nxt == S_REQ);
    w_pop       = (r_state == S_DATA) && ddr_wdata_req && (r_count != '0);
    w_burst_end = (r_state == S_WDONE) && (w_state_nxt == S_IDLE);
  end

  // Frame, line and burst bookkeeping.
  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) begin
      r_fsync_1d   <= 1'b0;
      r_fs_pend    <= 1'b0;
      r_active     <= 1'b0;
      r_frame_cnt  <= '0;
      r_part_l     <= '0;
      r_line       <= '0;
      r_burst_off  <= '0;
      r_frame_done <= 1'b0;
      r_waddr      <= ADDR_OFFSET[ADDR_WIDTH-1:0];
      r_wr_len     <= '0;
      r_req_cnt    <= '0;
      r_wdone_seen <= 1'b0;
    end else begin
      r_fsync_1d   <= wr_fsync;
      r_frame_done <= 1'b0;
      if (w_fs_rise)    r_fs_pend <= 1'b1;
      else if (w_apply) r_fs_pend <= 1'b0;
      if (w_apply) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_WIDTH'(1);
        r_part_l    <= ddr_part;
        r_line      <= '0;
        r_burst_off <= '0;
        r_active    <= 1'b1;
      end
      if (w_launch) begin
        r_wr_len  <= LEN_WIDTH'(w_blen);
        r_waddr   <= w_addr;
        r_req_cnt <= '0;
      end else if ((r_state == S_DATA) && ddr_wdata_req) begin
        r_req_cnt <= r_req_cnt + LEN_WIDTH'(1);
      end
      if (w_burst_end)                          r_wdone_seen <= 1'b0;
      else if ((r_state == S_DATA) && ddr_wdone) r_wdone_seen <= 1'b1;
      if (w_burst_end) begin
        if (w_off_sum == 32'(DDR_LINE)) begin
          r_burst_off <= '0;
          r_line      <= r_line + LINE_W'(1);
          if (32'(r_line) + 32'd1 == 32'(V_NUM)) begin
            r_frame_done <= 1'b1;
            r_active     <= 1'b0;
          end
        end else begin
          r_burst_off <= OFF_W'(w_off_sum);
        end
      end
    end
  end

  // Packer control and FIFO pointers; a frame start flushes both.
  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn || w_apply) begin
      r_word_cnt  <= '0;
      r_pack_cnt  <= '0;
      r_pack_line <= '0;
      r_push_v    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_push_v <= w_accept && (r_pack_cnt == PCNT_W'(LANES - 1));
      if (w_accept) begin
        if (r_word_cnt == WCNT_W'(WORDS_LINE - 1)) begin
          r_word_cnt  <= '0;
          r_pack_cnt  <= '0;
          r_pack_line <= r_pack_line + LINE_W'(1);
        end else begin
          r_word_cnt <= r_word_cnt + WCNT_W'(1);
          r_pack_cnt <= r_pack_cnt + PCNT_W'(1);
        end
      end
      if (r_push_v && w_full) r_ovf <= 1'b1;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    end
  end

  // NOTE: FIFO storage and the pack shift register carry no reset; pointers define validity.
  always_ff @(posedge ddr_clk) begin
    if (w_accept)  r_pack_data[32'(r_pack_cnt) * RAM_WIDTH +: RAM_WIDTH] <= wr_data;
    if (w_push_ok) r_mem[r_wr_ptr] <= r_pack_data;
  end

  // A pull with the FIFO empty leaves the previous word on the bus.
  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn)  r_wdata <= '0;
    else if (w_pop) r_wdata <= r_mem[r_rd_ptr];
  end

  assign ddr_waddr  = r_waddr;
  assign ddr_wr_len = r_wr_len;
  assign ddr_wdata  = r_wdata;
  assign frame_done = r_frame_done;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_rotate_wr_cell.sv
// Directed bench for rotate_wr_cell: a simple DDR controller model serves bursts
// while the stimulus streams numbered words; expected values are hand-derived.
module tb_rotate_wr_cell;

  localparam int V_NUM_TB = 4;
  localparam logic [26:0] PAR1  = 27'h400_0000;
  localparam logic [26:0] PART2 = 27'h200_0000;

  logic         ddr_clk = 1'b0;
  logic         ddr_rstn, wr_fsync, wr_en, ddr_wrdy, ddr_wdata_req, ddr_wdone;
  logic [31:0]  wr_data;
  logic [1:0]   ddr_part;
  logic         ddr_wreq, frame_done, ovf;
  logic [26:0]  ddr_waddr;
  logic [15:0]  ddr_wr_len;
  logic [255:0] ddr_wdata;

  always #5 ddr_clk = ~ddr_clk;

  rotate_wr_cell #(.V_NUM(V_NUM_TB)) dut (
    .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn), .wr_fsync(wr_fsync), .wr_en(wr_en),
    .wr_data(wr_data), .ddr_part(ddr_part), .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr),
    .ddr_wr_len(ddr_wr_len), .ddr_wrdy(ddr_wrdy), .ddr_wdata_req(ddr_wdata_req),
    .ddr_wdata(ddr_wdata), .ddr_wdone(ddr_wdone), .frame_done(frame_done), .ovf(ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int n_ok;
  logic [26:0]  ba  [16];
  logic [15:0]  bl  [16];
  logic [255:0] bf  [16];
  logic [255:0] bla [16];
  logic         bfd [16];
  bit           ok, q;
  int           fd_base;

  always @(posedge ddr_clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_word(input int base);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(base + k);
    return w;
  endfunction

  task automatic step();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic do_reset();
    ddr_rstn = 1'b0; wr_fsync = 1'b0; wr_en = 1'b0; wr_data = '0; ddr_part = '0;
    ddr_wrdy = 1'b0; ddr_wdata_req = 1'b0; ddr_wdone = 1'b0;
    repeat (3) step();
    ddr_rstn = 1'b1;
    step();
  endtask

  task automatic frame_start(input logic [1:0] part);
    ddr_part = part;
    wr_fsync = 1'b1;
    repeat (3) step();
    wr_fsync = 1'b0;
    step();
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = 32'(base + i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic quiet(input int n, output bit res);
    res = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (ddr_wreq !== 1'b0) res = 1'b0;
    end
  endtask

  task automatic serve_burst(input int hold, input int fs_at,
                             output logic [26:0] addr, output logic [15:0] len,
                             output logic [255:0] first_d, output logic [255:0] last_d,
                             output logic fd, output bit done_ok);
    int waited = 0;
    bit stable = 1'b1;
    done_ok = 1'b0; fd = 1'b0; addr = '0; len = '0; first_d = '0; last_d = '0;
    while (ddr_wreq !== 1'b1 && waited < 20000) begin
      step();
      waited++;
    end
    if (ddr_wreq !== 1'b1) begin
      check("wreq_timeout", ddr_wreq, 1);
      return;
    end
    addr = ddr_waddr;
    len  = ddr_wr_len;
    for (int k = 0; k < hold; k++) begin
      step();
      if (ddr_wreq !== 1'b1 || ddr_waddr !== addr || ddr_wr_len !== len || ddr_wdata !== '0)
        stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    ddr_wrdy = 1'b1;
    step();
    ddr_wrdy = 1'b0;
    if (hold > 0) check("wreq_drop", ddr_wreq, 0);
    for (int i = 0; i < int'(len) && i < 256; i++) begin
      if (i == fs_at) wr_fsync = 1'b1;
      ddr_wdata_req = 1'b1;
      step();
      if (i == 0) first_d = ddr_wdata;
      last_d = ddr_wdata;
    end
    ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b1;
    step();
    ddr_wdone = 1'b0;
    fd = frame_done;
    done_ok = 1'b1;
  endtask

  task automatic serve_n(input int first, input int n);
    n_ok = 0;
    for (int b = first; b < first + n; b++) begin
      serve_burst(0, -1, ba[b], bl[b], bf[b], bla[b], bfd[b], ok);
      if (!ok) break;
      n_ok++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and one line at part 0.
    do_reset();
    check("rst_wreq", ddr_wreq, 0);
    check("rst_waddr", ddr_waddr, 0);
    check("rst_len", ddr_wr_len, 0);
    check("rst_wdata", ddr_wdata, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_ovf", ovf, 0);

    frame_start(2'b00);
    stream(512, 0);
    step();
    check("latency_min", ddr_wreq, 0);
    stream(928, 512);
    serve_n(0, 3);
    check("l0_bursts", n_ok, 3);
    check("l0_addr0", ba[0], PAR1 | 27'd0);
    check("l0_addr1", ba[1], PAR1 | 27'd512);
    check("l0_addr2", ba[2], PAR1 | 27'd1024);
    check("l0_len0", bl[0], 64);
    check("l0_len1", bl[1], 64);
    check("l0_len2", bl[2], 52);
    check("l0_first", bf[0], exp_word(0));
    check("l0_last", bla[2], exp_word(1432));
    quiet(30, q);
    check("l0_no_4th", q, 1);

    // Three lines at part 2 with the controller running concurrently.
    do_reset();
    frame_start(2'b10);
    fork
      stream(3 * 1440, 0);
      serve_n(0, 9);
    join
    check("p2_bursts", n_ok, 9);
    check("p2_addr4", ba[4], PAR1 | PART2 | 27'd1952);
    check("p2_addr8", ba[8], PAR1 | PART2 | 27'd3904);
    check("p2_len8", bl[8], 52);
    check("p2_line1_first", bf[3], exp_word(1440));
    check("p2_last", bla[8], exp_word(4312));
    check("p2_no_ovf", ovf, 0);

    // Request held 20 cycles without ddr_wrdy.
    do_reset();
    frame_start(2'b00);
    stream(1440, 0);
    serve_burst(20, -1, ba[0], bl[0], bf[0], bla[0], bfd[0], ok);
    check("hold_first", bf[0], exp_word(0));
    check("hold_len", bl[0], 64);

    // Overflow: 2100 words with no data pulls.
    do_reset();
    frame_start(2'b00);
    stream(2100, 0);
    check("ovf_set", ovf, 1);
    serve_n(0, 4);
    check("ovf_bursts", n_ok, 4);
    check("ovf_b3_first", bf[3], exp_word(1440));
    check("ovf_b3_last", bla[3], exp_word(1944));
    quiet(30, q);
    check("ovf_no_5th", q, 1);
    check("ovf_sticky", ovf, 1);
    frame_start(2'b00);
    check("ovf_cleared", ovf, 0);

    // Frame sync during the second burst's data phase.
    do_reset();
    frame_start(2'b00);
    stream(1440, 0);
    serve_burst(0, -1, ba[0], bl[0], bf[0], bla[0], bfd[0], ok);
    serve_burst(0, 10, ba[1], bl[1], bf[1], bla[1], bfd[1], ok);
    wr_fsync = 1'b0;
    check("fsmid_len", bl[1], 64);
    check("fsmid_last", bla[1], exp_word(1016));
    quiet(20, q);
    check("fsmid_flushed", q, 1);
    stream(1440, 5000);
    serve_burst(0, -1, ba[2], bl[2], bf[2], bla[2], bfd[2], ok);
    check("fsmid_addr", ba[2], 27'd0);
    check("fsmid_len2", bl[2], 64);
    check("fsmid_first", bf[2], exp_word(5000));

    // Whole frame of V_NUM_TB lines plus one extra line of words.
    do_reset();
    fd_base = fd_cnt;
    frame_start(2'b00);
    fork
      stream(5 * 1440, 0);
      serve_n(0, 3 * V_NUM_TB);
    join
    check("ff_bursts", n_ok, 3 * V_NUM_TB);
    check("ff_last_addr", ba[11], PAR1 | 27'd5344);
    check("ff_last_data", bla[11], exp_word(5752));
    check("ff_fdone_pre", bfd[10], 0);
    check("ff_fdone", bfd[11], 1);
    quiet(50, q);
    check("ff_no_more", q, 1);
    check("ff_fdone_cnt", fd_cnt - fd_base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotate_wr_cell.md
Name: rotate_wr_cell

Overview:
- Write-side counterpart of the DDR rotate read path. Accepts a 32-bit RAM-word pixel stream in the ddr_clk domain and packs 8 words into each 256-bit DDR word.
- Buffers packed words in a circular FIFO and issues fixed-length DDR write bursts line by line. Addresses use the same {frame parity, part, line offset} map the read cells decode, so a frame written here is readable by them.

Parameters:
- ADDR_WIDTH, 27, DDR address width.
- ADDR_OFFSET, 32'h0000_0000, base added to every burst address.
- H_NUM, 1920, pixels per line.
- V_NUM, 1080, lines per frame.
- DQ_WIDTH, 32, DDR DQ width; DDR word = 8*DQ_WIDTH = 256 bits.
- LEN_WIDTH, 16, width of ddr_wr_len.
- PIX_WIDTH, 24, bits per pixel.
- RAM_WIDTH, 32, input word width.
- LINE_ADDR_WIDTH, 19, width of the in-part line address field.
- FRAME_CNT_WIDTH, 8, frame counter width.
- BURST_LEN, 64, maximum DDR words per burst.
- FIFO_DEPTH, 256, packed-word FIFO depth (power of 2).

Ports:
- ddr_clk, in, 1, sole clock.
- ddr_rstn, in, 1, synchronous active-low reset.
- wr_fsync, in, 1, frame sync level; a rising edge starts a frame.
- wr_en, in, 1, wr_data valid this cycle.
- wr_data, in, RAM_WIDTH, packed pixel word.
- ddr_part, in, 2, buffer partition; latched when a frame start is applied.
- ddr_wreq, out, 1, burst request; held until ddr_wrdy.
- ddr_waddr, out, ADDR_WIDTH, burst start address; stable while ddr_wreq=1.
- ddr_wr_len, out, LEN_WIDTH, burst length in DDR words; stable while ddr_wreq=1.
- ddr_wrdy, in, 1, request accepted.
- ddr_wdata_req, in, 1, controller pulls one DDR word.
- ddr_wdata, out, 8*DQ_WIDTH, write data.
- ddr_wdone, in, 1, burst complete pulse.
- frame_done, out, 1, one-cycle pulse after the last burst of line V_NUM is done.
- ovf, out, 1, sticky overflow flag; cleared on frame start.

Behaviour:
- Derived constants:
  - WORDS_LINE = H_NUM*PIX_WIDTH/RAM_WIDTH = 1440.
  - DDR_LINE = WORDS_LINE/8 = 180.
  - LINE_STRIDE = DDR_LINE*8 = 1440, in 32-bit address units.
- Reset (ddr_rstn=0, synchronous):
  - Outputs: ddr_wreq=0, ddr_waddr=ADDR_OFFSET, ddr_wr_len=0, ddr_wdata=0, frame_done=0, ovf=0.
  - State: FSM=IDLE, FIFO empty, packer count 0, frame_cnt=0, frame inactive.
  - All input words are dropped until the first wr_fsync rising edge.
- Edge detect: wr_fsync is registered; fs_rise = wr_fsync & ~wr_fsync_1d. fs_rise sets fs_pend.
- fs_pend is applied only in IDLE. Applying it:
  - frame_cnt+1; latch ddr_part.
  - line=0, burst_off=0.
  - Flush FIFO and packer; clear ovf; frame active.
  - Clear fs_pend.
- While fs_pend=1, wr_en words are dropped.
- Packer: the first word of each group of 8 goes to bits [31:0], the 8th to [255:224]. The packed word is written to the FIFO the cycle after the 8th wr_en. The packer count resets at each line boundary (every 1440 words).
- FIFO full at the packed-word write: the word is dropped and ovf=1 (sticky). Counters still advance.
- Burst length: blen = min(BURST_LEN, DDR_LINE - burst_off). With defaults this gives 64, 64, 52 per line.
- FSM:
  - IDLE -> REQ when the frame is active, line < V_NUM, and fifo_count >= blen. In the same cycle: ddr_wr_len=blen and ddr_waddr = {frame_cnt[0], ddr_part_l, line*LINE_STRIDE + burst_off*8} + ADDR_OFFSET, with the inner field LINE_ADDR_WIDTH bits.
  - REQ: ddr_wreq=1 until ddr_wrdy=1, then DATA with ddr_wreq=0.
  - DATA: each ddr_wdata_req pops one FIFO word; ddr_wdata is valid 1 cycle after the req. After blen pops go to WDONE. A req with the FIFO empty is a protocol error: output the last word and do not pop.
  - WDONE: wait for ddr_wdone (it may coincide with the last pop's data cycle). Then burst_off += blen. If burst_off reaches DDR_LINE: burst_off=0, line+1. If line reaches V_NUM: frame_done pulse, frame inactive. Return to IDLE.
- A rising edge mid-burst only sets fs_pend. The burst finishes normally and the frame restart is applied in the following IDLE cycle.
- Words arriving after line V_NUM has been fully packed are dropped (no ovf).
- Latency: the first request can assert no earlier than 2 cycles after the 512th word of a line (the 64th packed word).

Test Plan:
- Reset, then fs_rise and 1440 consecutive wr_en words with values 0..1439 -> exactly three requests. Lengths 64/64/52 at addresses 0/512/1024 for frame parity 1, part 0 (bit26=1). First ddr_wdata = {7,6,...,0} in 32-bit lanes.
- ddr_part=2'b10 and 3 lines streamed -> line 2, burst 3 address = {1,2'b10, 2880+1024} + ADDR_OFFSET; 9 bursts in total.
- ddr_wrdy withheld 20 cycles -> ddr_wreq, ddr_waddr and ddr_wr_len held stable for all 20 cycles; no data popped.
- Controller stalls ddr_wdata_req while 2100 words stream in -> 262 packed words, FIFO holds 256, ovf=1 and stays 1 until the next fs_rise clears it.
- fs_rise during DATA of the second burst -> that burst completes with 64 pops. The next request uses line 0, burst_off 0, and toggled frame parity.
- Full 1080-line frame -> 3240 bursts, single frame_done pulse after the last ddr_wdone. Further words produce no requests.
